// File: rtl/time_set_ctrl_pkg.sv
// Shared clock definitions: adjust-FSM state encodings, default time moduli,
// button-priority resolution and a BCD range helper.
package time_set_ctrl_pkg;

    // Default moduli for the time counter and the adjust controller.
    localparam int HR_MOD_DEFAULT  = 24;
    localparam int MIN_MOD_DEFAULT = 60;

    // Adjust FSM encodings, kept as plain constants so older RTL can share them.
    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_ADJ_HR  = 2'd1;
    localparam logic [1:0] ST_ADJ_MIN = 2'd2;

    // Single action chosen from the five buttons in one cycle.
    typedef enum logic [2:0] {
        ACT_NONE    = 3'd0,
        ACT_COMMIT  = 3'd1,
        ACT_INC     = 3'd2,
        ACT_DEC     = 3'd3,
        ACT_SEL_MIN = 3'd4,
        ACT_SEL_HR  = 3'd5
    } act_e;

    // Resolve simultaneous button pulses: C > U > D > R > L.
    function automatic act_e resolve_buttons(
        input logic c,
        input logic u,
        input logic d,
        input logic r,
        input logic l
    );
        act_e act;
        if (c) begin
            act = ACT_COMMIT;
        end else if (u) begin
            act = ACT_INC;
        end else if (d) begin
            act = ACT_DEC;
        end else if (r) begin
            act = ACT_SEL_MIN;
        end else if (l) begin
            act = ACT_SEL_HR;
        end else begin
            act = ACT_NONE;
        end
        return act;
    endfunction

    // True when a two-digit BCD value is well formed and below the modulus.
    function automatic logic bcd2_in_range(
        input logic [3:0] tens,
        input logic [3:0] units,
        input int         mod
    );
        int value;
        value = (int'(tens) * 10) + int'(units);
        return (tens <= 4'd9) && (units <= 4'd9) && (value < mod);
    endfunction

endpackage

// File: rtl/time_set_ctrl_bcd_field_step.sv
// bcd_field_step: combinational +1/-1 step of a two-digit BCD field with
// wrap at the modulus. Input is assumed in range; output is always in range.
module bcd_field_step #(
    parameter int MOD    = 60,
    parameter int TENS_W = 3
) (
    input  logic [TENS_W-1:0] tens_i,
    input  logic [3:0]        units_i,
    input  logic              dec_i,
    output logic [TENS_W-1:0] tens_o,
    output logic [3:0]        units_o
);

    // Largest legal value of the field, split into its BCD digits.
    localparam logic [TENS_W-1:0] MAX_TENS  = TENS_W'((MOD - 1) / 10);
    localparam logic [3:0]        MAX_UNITS = 4'((MOD - 1) % 10);
    localparam logic [TENS_W-1:0] ONE_TENS  = TENS_W'(1);
    localparam logic [TENS_W-1:0] ZERO_TENS = TENS_W'(0);

    logic at_max_s;
    logic at_zero_s;

    assign at_max_s  = (tens_i == MAX_TENS) && (units_i == MAX_UNITS);
    assign at_zero_s = (tens_i == ZERO_TENS) && (units_i == 4'd0);

    // Next field value: wrap at the ends, carry/borrow between the digits.
    always_comb begin
        tens_o  = tens_i;
        units_o = units_i;
        if (dec_i) begin
            if (at_zero_s) begin
                tens_o  = MAX_TENS;
                units_o = MAX_UNITS;
            end else if (units_i == 4'd0) begin
                tens_o  = tens_i - ONE_TENS;
                units_o = 4'd9;
            end else begin
                tens_o  = tens_i;
                units_o = units_i - 4'd1;
            end
        end else begin
            if (at_max_s) begin
                tens_o  = ZERO_TENS;
                units_o = 4'd0;
            end else if (units_i >= 4'd9) begin
                tens_o  = tens_i + ONE_TENS;
                units_o = 4'd0;
            end else begin
                tens_o  = tens_i;
                units_o = units_i + 4'd1;
            end
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: button-driven time-setting controller. Captures the running
// time into shadow registers, lets the user edit hours/minutes in BCD with a
// blinking selected field, and commits with a one-cycle load strobe.
module time_set_ctrl
    import time_set_ctrl_pkg::*;
#(
    parameter int HR_MOD  = HR_MOD_DEFAULT,
    parameter int MIN_MOD = MIN_MOD_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btnC,
    input  logic       btnU,
    input  logic       btnD,
    input  logic       btnL,
    input  logic       btnR,
    input  logic       tick,
    input  logic [1:0] H1_in,
    input  logic [3:0] H2_in,
    input  logic [2:0] M1_in,
    input  logic [3:0] M2_in,
    output logic [1:0] H1_ld,
    output logic [3:0] H2_ld,
    output logic [2:0] M1_ld,
    output logic [3:0] M2_ld,
    output logic       ld,
    output logic       clr_sec,
    output logic       adj,
    output logic       sel,
    output logic       blank
);

    logic [1:0] state_q, state_d;
    logic [1:0] h1_q, h1_d;
    logic [3:0] h2_q, h2_d;
    logic [2:0] m1_q, m1_d;
    logic [3:0] m2_q, m2_d;
    logic       ld_q, ld_d;
    logic       clr_sec_q, clr_sec_d;
    logic       adj_q, adj_d;
    logic       sel_q, sel_d;
    logic       blank_q, blank_d;

    act_e       act_s;
    logic       edit_s;
    logic       step_dec_s;
    logic       hr_in_ok_s;
    logic       min_in_ok_s;
    logic [1:0] hr_tens_step_s;
    logic [3:0] hr_units_step_s;
    logic [2:0] min_tens_step_s;
    logic [3:0] min_units_step_s;

    assign act_s       = resolve_buttons(btnC, btnU, btnD, btnR, btnL);
    assign step_dec_s  = (act_s == ACT_DEC);

    // Inputs from the counter are only trusted if they are legal BCD in range;
    // anything else is captured as 00 so the shadow never holds garbage.
    assign hr_in_ok_s  = bcd2_in_range({2'b00, H1_in}, H2_in, HR_MOD);
    assign min_in_ok_s = bcd2_in_range({1'b0, M1_in}, M2_in, MIN_MOD);

    bcd_field_step #(
        .MOD    (HR_MOD),
        .TENS_W (2)
    ) u_hr_step (
        .tens_i  (h1_q),
        .units_i (h2_q),
        .dec_i   (step_dec_s),
        .tens_o  (hr_tens_step_s),
        .units_o (hr_units_step_s)
    );

    bcd_field_step #(
        .MOD    (MIN_MOD),
        .TENS_W (3)
    ) u_min_step (
        .tens_i  (m1_q),
        .units_i (m2_q),
        .dec_i   (step_dec_s),
        .tens_o  (min_tens_step_s),
        .units_o (min_units_step_s)
    );

    // FSM next state, shadow register updates and commit strobes.
    always_comb begin
        state_d   = state_q;
        h1_d      = h1_q;
        h2_d      = h2_q;
        m1_d      = m1_q;
        m2_d      = m2_q;
        ld_d      = 1'b0;
        clr_sec_d = 1'b0;
        edit_s    = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (act_s == ACT_COMMIT) begin
                    state_d = ST_ADJ_HR;
                    if (hr_in_ok_s) begin
                        h1_d = H1_in;
                        h2_d = H2_in;
                    end else begin
                        h1_d = 2'd0;
                        h2_d = 4'd0;
                    end
                    if (min_in_ok_s) begin
                        m1_d = M1_in;
                        m2_d = M2_in;
                    end else begin
                        m1_d = 3'd0;
                        m2_d = 4'd0;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_ADJ_HR, ST_ADJ_MIN: begin
                case (act_s)
                    ACT_COMMIT: begin
                        state_d   = ST_RUN;
                        ld_d      = 1'b1;
                        clr_sec_d = 1'b1;
                    end
                    ACT_INC, ACT_DEC: begin
                        edit_s = 1'b1;
                        if (state_q == ST_ADJ_HR) begin
                            h1_d = hr_tens_step_s;
                            h2_d = hr_units_step_s;
                        end else begin
                            m1_d = min_tens_step_s;
                            m2_d = min_units_step_s;
                        end
                    end
                    ACT_SEL_MIN: state_d = ST_ADJ_MIN;
                    ACT_SEL_HR:  state_d = ST_ADJ_HR;
                    ACT_NONE:    state_d = state_q;
                    default:     state_d = state_q;
                endcase
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Blink phase: off in RUN, forced visible on any edit or state change.
    always_comb begin
        if (state_d == ST_RUN) begin
            blank_d = 1'b0;
        end else if (edit_s || (state_d != state_q)) begin
            blank_d = 1'b0;
        end else if (tick) begin
            blank_d = ~blank_q;
        end else begin
            blank_d = blank_q;
        end
    end

    assign adj_d = (state_d != ST_RUN);
    assign sel_d = (state_d == ST_ADJ_MIN);

    // State, shadow and output registers; reset discards any pending edit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RUN;
            h1_q      <= 2'd0;
            h2_q      <= 4'd0;
            m1_q      <= 3'd0;
            m2_q      <= 4'd0;
            ld_q      <= 1'b0;
            clr_sec_q <= 1'b0;
            adj_q     <= 1'b0;
            sel_q     <= 1'b0;
            blank_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            h1_q      <= h1_d;
            h2_q      <= h2_d;
            m1_q      <= m1_d;
            m2_q      <= m2_d;
            ld_q      <= ld_d;
            clr_sec_q <= clr_sec_d;
            adj_q     <= adj_d;
            sel_q     <= sel_d;
            blank_q   <= blank_d;
        end
    end

    assign H1_ld   = h1_q;
    assign H2_ld   = h2_q;
    assign M1_ld   = m1_q;
    assign M2_ld   = m2_q;
    assign ld      = ld_q;
    assign clr_sec = clr_sec_q;
    assign adj     = adj_q;
    assign sel     = sel_q;
    assign blank   = blank_q;

endmodule
